// File: rtl/instr_fetch_controller.sv
// Instruction fetch controller for the multicycle core.
// Owns the architectural PC, issues one instruction-memory read per
// fetch_start, waits out a variable memory latency with a timeout, and
// hands the fetched word to the instruction register with a one-cycle
// load strobe. Misaligned fetch addresses and memory timeouts are
// reported as one-cycle fault pulses.
module instr_fetch_controller #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_start,
    input  logic        pc_write,
    input  logic [31:0] pc_next,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        ir_load,
    output logic [31:0] ir_data,
    output logic [31:0] pc,
    output logic [31:0] fetch_pc,
    output logic        busy,
    output logic        fetch_done,
    output logic        misalign_fault,
    output logic        timeout_fault
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      ir_q, ir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             misalign_q, misalign_d;
    logic             timeout_q, timeout_d;

    logic [31:0] start_addr;
    logic        start_aligned;
    logic        start_go;
    logic        start_bad;
    logic        accept;
    logic        rvalid_hit;
    logic        cnt_expired;

    // Fetch-start address selection and the qualified FSM events
    always_comb begin
        // A PC write in the same cycle as fetch_start redirects the fetch
        start_addr    = pc_write ? pc_next : pc_q;
        start_aligned = (start_addr[1:0] == 2'b00);
        start_go      = (state_q == S_IDLE) && fetch_start && start_aligned;
        start_bad     = (state_q == S_IDLE) && fetch_start && !start_aligned;
        accept        = (state_q == S_REQ) && mem_ready;
        rvalid_hit    = (state_q == S_WAIT) && mem_rvalid;
        cnt_expired   = (state_q == S_WAIT) && (cnt_q == CNT_LAST);
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_go) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (accept) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // Data arriving on the last allowed cycle still completes
                if (rvalid_hit) begin
                    state_d = S_DONE;
                end else if (cnt_expired) begin
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM outputs decoded from the current state
    always_comb begin
        mem_req    = 1'b0;
        ir_load    = 1'b0;
        fetch_done = 1'b0;
        busy       = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_REQ: begin
                mem_req = 1'b1;
                busy    = 1'b1;
            end
            S_WAIT: begin
                busy = 1'b1;
            end
            S_DONE: begin
                ir_load    = 1'b1;
                fetch_done = 1'b1;
                busy       = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Datapath next-state: PC, latched fetch address, IR word, timeout counter, fault pulses
    always_comb begin
        pc_d       = pc_q;
        addr_d     = addr_q;
        fetch_pc_d = fetch_pc_q;
        ir_d       = ir_q;
        cnt_d      = cnt_q;
        misalign_d = start_bad;
        timeout_d  = cnt_expired && !mem_rvalid;

        // PC writes are honoured in every state; an in-flight fetch keeps its own copy
        if (pc_write) begin
            pc_d = pc_next;
        end

        if (start_go) begin
            addr_d     = start_addr;
            fetch_pc_d = start_addr;
        end

        if (accept) begin
            cnt_d = '0;
        end else if (state_q == S_WAIT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (rvalid_hit) begin
            ir_d = mem_rdata;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            addr_q     <= '0;
            fetch_pc_q <= RESET_PC;
            ir_q       <= '0;
            cnt_q      <= '0;
            misalign_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            fetch_pc_q <= fetch_pc_d;
            ir_q       <= ir_d;
            cnt_q      <= cnt_d;
            misalign_q <= misalign_d;
            timeout_q  <= timeout_d;
        end
    end

    // Registered outputs
    always_comb begin
        pc             = pc_q;
        mem_addr       = addr_q;
        fetch_pc       = fetch_pc_q;
        ir_data        = ir_q;
        misalign_fault = misalign_q;
        timeout_fault  = timeout_q;
    end

endmodule
